// File: rtl/lockin_controller.sv
// lockin_controller: sequences one buffer of samples through DDFS -> mixer -> CIC.
// Latency: 5 cycles per sample when DDFS and mixer answer in their first wait cycle.
// Backpressure: blocks in WAIT_DDFS / WAIT_MIX until the matching valid arrives.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-low reset
//   tuning_word_in         reference frequency word, latched on start
//   ddfs_tuning_word       latched word, zero-extended, to the DDFS
//   buffer_ready           start request, sampled only while idle
//   buffer_addr/data       sample buffer read port (1-cycle synchronous read)
//   ddfs_sample_en         one-cycle DDFS sample request
//   ddfs_valid_out/sine/cosine   DDFS response
//   mixer_start_en         one-cycle mixer start, with mixer_*_in held stable
//   mixer_*_out/valid_out  mixer I/Q response
//   cic_*_in/cic_valid_in  I/Q result plus sample index, one-cycle strobe
//
// Optional build macro LOCKIN_TIMEOUT_EN adds TIMEOUT_CYCLES: a wait state that
// sees no valid for TIMEOUT_CYCLES cycles abandons the buffer and returns to idle.

module lockin_controller #(
  parameter int BUFFER_DEPTH       = 512,
  parameter int DATA_WIDTH         = 24,
  parameter int FREQUENCY_SIZE_IN  = 13,
  parameter int FREQUENCY_SIZE_OUT = 16,
  parameter int SIN_WIDTH          = 18,
`ifdef LOCKIN_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES     = 1024,
`endif
  localparam int AW = $clog2(BUFFER_DEPTH),
  localparam int PW = DATA_WIDTH + SIN_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FREQUENCY_SIZE_IN-1:0]  tuning_word_in,
  output logic [FREQUENCY_SIZE_OUT-1:0] ddfs_tuning_word,
  input  logic                          buffer_ready,
  output logic [AW-1:0]                 buffer_addr,
  input  logic [DATA_WIDTH-1:0]         buffer_data,
  output logic                          mixer_start_en,
  output logic signed [DATA_WIDTH-1:0]  mixer_data_in,
  output logic signed [SIN_WIDTH-1:0]   mixer_sine_in,
  output logic signed [SIN_WIDTH-1:0]   mixer_cosine_in,
  input  logic signed [PW-1:0]          mixer_phase_out,
  input  logic signed [PW-1:0]          mixer_quadrature_out,
  input  logic                          mixer_valid_out,
  output logic signed [PW-1:0]          cic_phase_in,
  output logic signed [PW-1:0]          cic_quadrature_in,
  output logic [AW-1:0]                 cic_addr_in,
  output logic                          cic_valid_in,
  output logic                          ddfs_sample_en,
  input  logic                          ddfs_valid_out,
  input  logic signed [SIN_WIDTH-1:0]   ddfs_sine_out,
  input  logic signed [SIN_WIDTH-1:0]   ddfs_cosine_out
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_DDFS = 3'd2;
  localparam logic [2:0] S_MIX       = 3'd3;
  localparam logic [2:0] S_WAIT_MIX  = 3'd4;
  localparam logic [2:0] S_OUT       = 3'd5;

  logic [2:0]    state;
  logic [AW-1:0] addr;

`ifdef LOCKIN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_cnt;
  // High on the last permitted wait cycle; no valid then means abort.
  logic          wait_expired;
  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Strobes decode straight from state so each lasts exactly one cycle and
  // all are low while reset holds the FSM in IDLE.
  assign ddfs_sample_en = (state == S_REQ);
  assign mixer_start_en = (state == S_MIX);
  assign cic_valid_in   = (state == S_OUT);

  // addr only moves in IDLE and OUT, so the read address is stable from the
  // request through the DDFS capture and buffer_data is valid by then.
  assign buffer_addr = addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_IDLE;
      addr              <= '0;
      ddfs_tuning_word  <= '0;
      mixer_data_in     <= '0;
      mixer_sine_in     <= '0;
      mixer_cosine_in   <= '0;
      cic_phase_in      <= '0;
      cic_quadrature_in <= '0;
      cic_addr_in       <= '0;
`ifdef LOCKIN_TIMEOUT_EN
      wait_cnt          <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (buffer_ready) begin
            ddfs_tuning_word <= FREQUENCY_SIZE_OUT'(tuning_word_in);
            addr             <= '0;
            state            <= S_REQ;
          end
        end

        S_REQ: begin
`ifdef LOCKIN_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT_DDFS;
        end

        S_WAIT_DDFS: begin
          if (ddfs_valid_out) begin
            mixer_data_in   <= buffer_data;
            mixer_sine_in   <= ddfs_sine_out;
            mixer_cosine_in <= ddfs_cosine_out;
            state           <= S_MIX;
          end
`ifdef LOCKIN_TIMEOUT_EN
          else if (wait_expired) begin
            addr  <= '0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_MIX: begin
`ifdef LOCKIN_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT_MIX;
        end

        S_WAIT_MIX: begin
          if (mixer_valid_out) begin
            cic_phase_in      <= mixer_phase_out;
            cic_quadrature_in <= mixer_quadrature_out;
            cic_addr_in       <= addr;
            state             <= S_OUT;
          end
`ifdef LOCKIN_TIMEOUT_EN
          else if (wait_expired) begin
            addr  <= '0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_OUT: begin
          if (addr == AW'(BUFFER_DEPTH - 1)) begin
            addr  <= '0;
            state <= S_IDLE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_REQ;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lockin_controller.sv
`timescale 1ns/1ps
module tb_lockin_controller;

  localparam int DEPTH = 512;
  localparam int DW    = 24;
  localparam int FIN   = 13;
  localparam int FOUT  = 16;
  localparam int SW    = 18;
  localparam int PW    = DW + SW;
  localparam int AW    = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [FIN-1:0]  tuning_word_in;
  logic [FOUT-1:0] ddfs_tuning_word;
  logic            buffer_ready;
  logic [AW-1:0]   buffer_addr;
  logic [DW-1:0]   buffer_data;
  logic            mixer_start_en;
  logic [DW-1:0]   mixer_data_in;
  logic [SW-1:0]   mixer_sine_in;
  logic [SW-1:0]   mixer_cosine_in;
  logic [PW-1:0]   mixer_phase_out;
  logic [PW-1:0]   mixer_quadrature_out;
  logic            mixer_valid_out;
  logic [PW-1:0]   cic_phase_in;
  logic [PW-1:0]   cic_quadrature_in;
  logic [AW-1:0]   cic_addr_in;
  logic            cic_valid_in;
  logic            ddfs_sample_en;
  logic            ddfs_valid_out;
  logic [SW-1:0]   ddfs_sine_out;
  logic [SW-1:0]   ddfs_cosine_out;

  lockin_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .tuning_word_in       (tuning_word_in),
    .ddfs_tuning_word     (ddfs_tuning_word),
    .buffer_ready         (buffer_ready),
    .buffer_addr          (buffer_addr),
    .buffer_data          (buffer_data),
    .mixer_start_en       (mixer_start_en),
    .mixer_data_in        (mixer_data_in),
    .mixer_sine_in        (mixer_sine_in),
    .mixer_cosine_in      (mixer_cosine_in),
    .mixer_phase_out      (mixer_phase_out),
    .mixer_quadrature_out (mixer_quadrature_out),
    .mixer_valid_out      (mixer_valid_out),
    .cic_phase_in         (cic_phase_in),
    .cic_quadrature_in    (cic_quadrature_in),
    .cic_addr_in          (cic_addr_in),
    .cic_valid_in         (cic_valid_in),
    .ddfs_sample_en       (ddfs_sample_en),
    .ddfs_valid_out       (ddfs_valid_out),
    .ddfs_sine_out        (ddfs_sine_out),
    .ddfs_cosine_out      (ddfs_cosine_out)
  );

  // Reference model: sample i of a buffer is mem[i]; the DDFS answers its
  // i-th request with sin_tab[i]/cos_tab[i]; the mixer answers its i-th start
  // with ph_tab[i]/qd_tab[i]. Sample i must therefore reach the CIC as
  // {ph_tab[i], qd_tab[i], i}, in order, once per sample.
  logic [DW-1:0] mem     [DEPTH];
  logic [SW-1:0] sin_tab [DEPTH];
  logic [SW-1:0] cos_tab [DEPTH];
  logic [PW-1:0] ph_tab  [DEPTH];
  logic [PW-1:0] qd_tab  [DEPTH];

  typedef struct packed {
    logic [PW-1:0] ph;
    logic [PW-1:0] qd;
    logic [AW-1:0] a;
  } exp_t;
  exp_t sb[$];

  logic [FOUT-1:0] exp_tw;
  logic [AW-1:0]   rd_addr_q;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  k_req = 0;
  int  m_req = 0;
  int  en_cnt = 0;
  int  cic_cnt = 0;
  bit  noise = 1'b1;
  bit  ddfs_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic fill_random();
    logic [63:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      r = rnd64(); mem[i]    = r[DW-1:0];
      r = rnd64(); sin_tab[i] = r[SW-1:0];
      r = rnd64(); cos_tab[i] = r[SW-1:0];
      r = rnd64(); ph_tab[i]  = r[PW-1:0];
      r = rnd64(); qd_tab[i]  = r[PW-1:0];
    end
  endtask

  function automatic logic any_output();
    return |{ddfs_tuning_word, buffer_addr, mixer_start_en, mixer_data_in,
             mixer_sine_in, mixer_cosine_in, cic_phase_in, cic_quadrature_in,
             cic_addr_in, cic_valid_in, ddfs_sample_en};
  endfunction

  // Called at #1 after an edge. Expects n results, pulses buffer_ready once.
  task automatic start_run(input logic [FIN-1:0] tw, input int n);
    k_req  = 0;
    m_req  = 0;
    exp_tw = FOUT'(tw);
    for (int i = 0; i < n; i++) sb.push_back('{ph: ph_tab[i], qd: qd_tab[i], a: AW'(i)});
    tuning_word_in = tw;
    buffer_ready   = 1'b1;
    @(posedge clk); #1;
    buffer_ready   = 1'b0;
    tuning_word_in = FIN'($urandom);
    check("start_tuning_word", 64'(ddfs_tuning_word), 64'(exp_tw));
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    while (sb.size() != 0 && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    check("run_outstanding_results", 64'(sb.size()), 64'd0);
  endtask

  // Sample buffer: data reflects the address presented one cycle earlier.
  initial begin
    buffer_data = '0;
    rd_addr_q   = '0;
    forever begin
      @(posedge clk); #1;
      if (noise) buffer_data = DW'($urandom);
      else       buffer_data = mem[rd_addr_q];
      rd_addr_q = buffer_addr;
    end
  end

  // DDFS responder with 1..4 cycles of latency.
  initial begin
    int idx;
    ddfs_valid_out  = 1'b0;
    ddfs_sine_out   = '0;
    ddfs_cosine_out = '0;
    forever begin
      @(posedge clk); #1;
      if (noise) begin
        ddfs_valid_out  = 1'($urandom);
        ddfs_sine_out   = SW'($urandom);
        ddfs_cosine_out = SW'($urandom);
      end else begin
        ddfs_valid_out = 1'b0;
        if (ddfs_sample_en) begin
          idx = k_req;
          k_req++;
          check("ddfs_req_addr", 64'(buffer_addr), 64'(idx));
          if (!ddfs_hold && idx < DEPTH) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            ddfs_valid_out  = 1'b1;
            ddfs_sine_out   = sin_tab[idx];
            ddfs_cosine_out = cos_tab[idx];
            @(posedge clk); #1;
            ddfs_valid_out  = 1'b0;
            ddfs_sine_out   = SW'($urandom);
            ddfs_cosine_out = SW'($urandom);
          end
        end
      end
    end
  end

  // Mixer responder: checks the operands it was handed, answers in 1..4 cycles.
  initial begin
    int idx;
    mixer_valid_out      = 1'b0;
    mixer_phase_out      = '0;
    mixer_quadrature_out = '0;
    forever begin
      @(posedge clk); #1;
      if (noise) begin
        mixer_valid_out      = 1'($urandom);
        mixer_phase_out      = PW'(rnd64());
        mixer_quadrature_out = PW'(rnd64());
      end else begin
        mixer_valid_out = 1'b0;
        if (mixer_start_en) begin
          idx = m_req;
          m_req++;
          if (idx < DEPTH) begin
            check("mixer_data_in",   64'(mixer_data_in),   64'(mem[idx]));
            check("mixer_sine_in",   64'(mixer_sine_in),   64'(sin_tab[idx]));
            check("mixer_cosine_in", 64'(mixer_cosine_in), 64'(cos_tab[idx]));
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            mixer_valid_out      = 1'b1;
            mixer_phase_out      = ph_tab[idx];
            mixer_quadrature_out = qd_tab[idx];
            @(posedge clk); #1;
            mixer_valid_out      = 1'b0;
            mixer_phase_out      = PW'(rnd64());
            mixer_quadrature_out = PW'(rnd64());
          end else begin
            check("mixer_start_in_range", 64'(idx), 64'(DEPTH - 1));
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every CIC strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (ddfs_sample_en) en_cnt++;
      if (cic_valid_in) begin
        cic_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_cic_valid: addr %0d, expected no strobe", cic_addr_in);
        end else begin
          e = sb.pop_front();
          check("cic_phase_in",      64'(cic_phase_in),      64'(e.ph));
          check("cic_quadrature_in", 64'(cic_quadrature_in), 64'(e.qd));
          check("cic_addr_in",       64'(cic_addr_in),       64'(e.a));
          check("ddfs_tuning_word",  64'(ddfs_tuning_word),  64'(exp_tw));
        end
      end
    end
  end

  initial begin
    int en0, cic0, c;
    logic [FIN-1:0] tw;
    reset          = 1'b0;
    buffer_ready   = 1'b0;
    tuning_word_in = '0;
    fill_random();

    // Reset held with all inputs toggling.
    repeat (5) begin
      @(posedge clk); #1;
      buffer_ready   = 1'($urandom);
      tuning_word_in = FIN'($urandom);
      check("reset_outputs_zero", 64'(any_output()), 64'd0);
      check("reset_sample_en",    64'(ddfs_sample_en), 64'd0);
    end
    buffer_ready = 1'b0;
    noise        = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_outputs_zero", 64'(any_output()), 64'd0);

    // Run 1: directed first sample, then a full random buffer.
    mem[0]     = 24'hAABBCC;
    sin_tab[0] = 18'h10000;
    cos_tab[0] = 18'h05555;
    ph_tab[0]  = 42'h123456789A;
    qd_tab[0]  = 42'h0987654321;
    en0 = en_cnt; cic0 = cic_cnt;
    start_run(13'h1ABC, DEPTH);
    wait_done(20000);
    repeat (20) @(posedge clk);
    #1;
    check("run1_sample_en_count", 64'(en_cnt - en0),  64'(DEPTH));
    check("run1_cic_count",       64'(cic_cnt - cic0), 64'(DEPTH));

    // Run 2: random buffer with a start pulse that must be ignored mid-run.
    fill_random();
    tw  = FIN'($urandom);
    en0 = en_cnt; cic0 = cic_cnt;
    start_run(tw, DEPTH);
    repeat (300) @(posedge clk);
    #1;
    tuning_word_in = ~tw;
    buffer_ready   = 1'b1;
    @(posedge clk); #1;
    buffer_ready   = 1'b0;
    wait_done(20000);
    repeat (30) @(posedge clk);
    #1;
    check("run2_sample_en_count", 64'(en_cnt - en0),  64'(DEPTH));
    check("run2_cic_count",       64'(cic_cnt - cic0), 64'(DEPTH));
    check("run2_idle_addr",       64'(buffer_addr),    64'd0);

    // Run 3: reset while sample 3 is in flight.
    fill_random();
    start_run(FIN'($urandom), 3);
    c = 0;
    while (k_req < 4 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("run3_reached_addr3", 64'(k_req), 64'd4);
    check("run3_sb_drained",    64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrun_reset_outputs_zero", 64'(any_output()), 64'd0);
    end
    reset = 1'b1;
    en0 = en_cnt; cic0 = cic_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_no_sample_en", 64'(en_cnt - en0),  64'd0);
    check("post_reset_no_cic",       64'(cic_cnt - cic0), 64'd0);

`ifdef LOCKIN_TIMEOUT_EN
    // DDFS never answers: the controller must give up and accept a new start.
    ddfs_hold = 1'b1;
    en0 = en_cnt; cic0 = cic_cnt;
    start_run(FIN'($urandom), 0);
    repeat (1100) @(posedge clk);
    #1;
    check("timeout_single_request", 64'(en_cnt - en0), 64'd1);
    buffer_ready = 1'b1;
    @(posedge clk); #1;
    buffer_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("timeout_restart_request", 64'(en_cnt - en0),  64'd2);
    check("timeout_no_cic",          64'(cic_cnt - cic0), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ddfs_hold = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
